// File: rtl/data_mem_responder.sv
// Single-request word memory responder: accepts one CPU load/store, waits LATENCY
// cycles, performs the access and holds the response until the CPU consumes it.
module data_mem_responder #(
    parameter int DEPTH   = 128,
    parameter int LATENCY = 2
) (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [2:0]  cnt_reg, cnt_next;
    logic        write_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic        resp_valid_reg, resp_valid_next;
    logic [31:0] resp_rdata_reg, resp_rdata_next;
    logic        resp_err_reg, resp_err_next;
    logic        load_req;
    logic        mem_we;
    logic        fault;
    logic [IDX_W-1:0] word_idx;
    logic [31:0] rd_word;

    // Storage must clear on reset, so it is a register array rather than a RAM macro.
    logic [31:0] mem_reg [DEPTH];

    // Index is taken from the word address only; anything beyond DEPTH faults instead of wrapping.
    assign fault    = (addr_reg[1:0] != 2'b00) || ({2'b00, addr_reg[31:2]} >= 32'(DEPTH));
    assign word_idx = addr_reg[IDX_W+1:2];
    assign rd_word  = mem_reg[word_idx];

    assign req_ready_o  = (state_reg == IDLE);
    assign resp_valid_o = resp_valid_reg;
    assign resp_rdata_o = resp_rdata_reg;
    assign resp_err_o   = resp_err_reg;

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        resp_valid_next = resp_valid_reg;
        resp_rdata_next = resp_rdata_reg;
        resp_err_next   = resp_err_reg;
        load_req        = 1'b0;
        mem_we          = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_valid_i) begin
                    load_req   = 1'b1;
                    cnt_next   = 3'(LATENCY - 1);
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (cnt_reg != 3'd0) begin
                    cnt_next = cnt_reg - 3'd1;
                end else begin
                    state_next      = RESP;
                    resp_valid_next = 1'b1;
                    resp_err_next   = fault;
                    resp_rdata_next = (!fault && !write_reg) ? rd_word : 32'd0;
                    mem_we          = !fault && write_reg;
                end
            end
            RESP: begin
                if (resp_ready_i) begin
                    state_next      = IDLE;
                    resp_valid_next = 1'b0;
                    resp_rdata_next = 32'd0;
                    resp_err_next   = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            cnt_reg        <= 3'd0;
            resp_valid_reg <= 1'b0;
            resp_rdata_reg <= 32'd0;
            resp_err_reg   <= 1'b0;
            write_reg      <= 1'b0;
            addr_reg       <= 32'd0;
            wdata_reg      <= 32'd0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            resp_valid_reg <= resp_valid_next;
            resp_rdata_reg <= resp_rdata_next;
            resp_err_reg   <= resp_err_next;
            if (load_req) begin
                write_reg <= req_write_i;
                addr_reg  <= req_addr_i;
                wdata_reg <= req_wdata_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= 32'd0;
            end
        end else if (mem_we) begin
            mem_reg[word_idx] <= wdata_reg;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: LATENCY=2 main instance plus a LATENCY=1 instance.
module tb_data_mem_responder;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b0;
    logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;

    logic        q1_valid = 1'b0, q1_write = 1'b0, r1_ready = 1'b0;
    logic [31:0] q1_addr = 32'd0, q1_wdata = 32'd0;
    logic        q1_ready, r1_valid, r1_err;
    logic [31:0] r1_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH(128), .LATENCY(LAT)) dut (
        .clk_i(clk), .rst_n(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
        .resp_rdata_o(resp_rdata), .resp_err_o(resp_err)
    );

    data_mem_responder #(.DEPTH(128), .LATENCY(1)) dut1 (
        .clk_i(clk), .rst_n(rst_n),
        .req_valid_i(q1_valid), .req_ready_o(q1_ready), .req_write_i(q1_write),
        .req_addr_i(q1_addr), .req_wdata_i(q1_wdata),
        .resp_valid_o(r1_valid), .resp_ready_i(r1_ready),
        .resp_rdata_o(r1_rdata), .resp_err_o(r1_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction on the LATENCY=2 instance, checking latency and response.
    task automatic do_req(input string tag, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] exp_rdata, input logic exp_err);
        int n;
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        n = 0;
        while (!req_ready && n < 20) begin tick(); n++; end
        tick();
        req_valid = 1'b0;
        n = 0;
        do begin tick(); n++; end while (!resp_valid && n < 20);
        check_eq({tag, "_lat"}, n, LAT);
        check_eq({tag, "_rdata"}, resp_rdata, exp_rdata);
        check_eq({tag, "_err"}, {31'd0, resp_err}, {31'd0, exp_err});
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check_eq({tag, "_drop"}, {31'd0, resp_valid}, 32'd0);
        $display("txn %s w=%0d addr=0x%08h rdata=0x%08h err=%0d", tag, w, a, resp_rdata, resp_err);
    endtask

    initial begin
        int acc_cyc[$];
        logic [31:0] rdq[$];
        int cyc;
        logic acc;
        logic [31:0] bb_addr [3];

        // Reset state, checked while reset is held
        #12;
        check_eq("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check_eq("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check_eq("rst_rdata", resp_rdata, 32'd0);
        check_eq("rst_err", {31'd0, resp_err}, 32'd0);
        rst_n = 1'b1;

        // Store then load, legal word
        do_req("st10", 1'b1, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0);
        do_req("ld10", 1'b0, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0);

        // Faults: out-of-range store must not alias onto word 0, misaligned store must not land
        do_req("st200", 1'b1, 32'h200, 32'h12345678, 32'd0, 1'b1);
        do_req("st11", 1'b1, 32'h11, 32'hCAFEF00D, 32'd0, 1'b1);
        do_req("ld13", 1'b0, 32'h13, 32'd0, 32'd0, 1'b1);
        do_req("ld200", 1'b0, 32'h200, 32'd0, 32'd0, 1'b1);
        do_req("ld0", 1'b0, 32'h0, 32'd0, 32'd0, 1'b0);
        do_req("ld10b", 1'b0, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0);
        do_req("ldhi", 1'b0, 32'h8000_0010, 32'd0, 32'd0, 1'b1);

        // Last legal word
        do_req("st1fc", 1'b1, 32'h1FC, 32'hA5A5_0001, 32'd0, 1'b0);
        do_req("ld1fc", 1'b0, 32'h1FC, 32'd0, 32'hA5A5_0001, 1'b0);

        // Stall in RESP with a competing request that must be ignored
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10;
        tick();
        req_write = 1'b1; req_wdata = 32'h0BAD_0BAD;
        for (int i = 0; i < LAT; i++) tick();
        for (int i = 0; i < 5; i++) begin
            check_eq("stall_valid", {31'd0, resp_valid}, 32'd1);
            check_eq("stall_rdata", resp_rdata, 32'hDEADBEEF);
            check_eq("stall_err", {31'd0, resp_err}, 32'd0);
            check_eq("stall_req_ready", {31'd0, req_ready}, 32'd0);
            $display("txn stall cycle %0d valid=%0d rdata=0x%08h", i, resp_valid, resp_rdata);
            tick();
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check_eq("stall_release_valid", {31'd0, resp_valid}, 32'd0);
        check_eq("stall_release_ready", {31'd0, req_ready}, 32'd1);
        do_req("ld10c", 1'b0, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0);

        // Reset while a store is waiting: no response, no write, storage cleared
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h4; req_wdata = 32'h5555_5555;
        tick();
        req_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check_eq("arst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check_eq("arst_req_ready", {31'd0, req_ready}, 32'd1);
        tick(); tick();
        #3 rst_n = 1'b1;
        do_req("ld4", 1'b0, 32'h4, 32'd0, 32'd0, 1'b0);
        do_req("ld10r", 1'b0, 32'h10, 32'd0, 32'd0, 1'b0);

        // Back-to-back loads with valid/ready held high
        bb_addr[0] = 32'h20; bb_addr[1] = 32'h24; bb_addr[2] = 32'h28;
        do_req("st20", 1'b1, 32'h20, 32'h1111_0000, 32'd0, 1'b0);
        do_req("st24", 1'b1, 32'h24, 32'h2222_0000, 32'd0, 1'b0);
        do_req("st28", 1'b1, 32'h28, 32'h3333_0000, 32'd0, 1'b0);
        req_valid = 1'b1; req_write = 1'b0; req_addr = bb_addr[0];
        resp_ready = 1'b1;
        cyc = 0;
        while (rdq.size() < 3 && cyc < 60) begin
            acc = req_valid && req_ready;
            tick();
            cyc++;
            if (acc) begin
                acc_cyc.push_back(cyc);
                if (acc_cyc.size() < 3) req_addr = bb_addr[acc_cyc.size()];
                else req_valid = 1'b0;
            end
            if (resp_valid) rdq.push_back(resp_rdata);
        end
        req_valid = 1'b0;
        resp_ready = 1'b0;
        check_eq("bb_accepts", acc_cyc.size(), 3);
        check_eq("bb_resps", rdq.size(), 3);
        if (acc_cyc.size() == 3) begin
            check_eq("bb_gap01", acc_cyc[1] - acc_cyc[0], LAT + 2);
            check_eq("bb_gap12", acc_cyc[2] - acc_cyc[1], LAT + 2);
        end
        if (rdq.size() == 3) begin
            check_eq("bb_rd0", rdq[0], 32'h1111_0000);
            check_eq("bb_rd1", rdq[1], 32'h2222_0000);
            check_eq("bb_rd2", rdq[2], 32'h3333_0000);
        end
        $display("txn back-to-back accepts=%0d responses=%0d", acc_cyc.size(), rdq.size());
        tick(); tick();

        // LATENCY=1 instance: response one cycle after accept
        q1_valid = 1'b1; q1_write = 1'b1; q1_addr = 32'h8; q1_wdata = 32'h7777_8888;
        tick();
        q1_valid = 1'b0;
        check_eq("l1_accept_state", {31'd0, q1_ready}, 32'd0);
        tick();
        check_eq("l1_st_valid", {31'd0, r1_valid}, 32'd1);
        check_eq("l1_st_err", {31'd0, r1_err}, 32'd0);
        r1_ready = 1'b1;
        tick();
        r1_ready = 1'b0;
        q1_valid = 1'b1; q1_write = 1'b0;
        tick();
        q1_valid = 1'b0;
        tick();
        check_eq("l1_ld_valid", {31'd0, r1_valid}, 32'd1);
        check_eq("l1_ld_rdata", r1_rdata, 32'h7777_8888);
        $display("txn lat1 load addr=0x00000008 rdata=0x%08h", r1_rdata);
        r1_ready = 1'b1;
        tick();
        r1_ready = 1'b0;
        check_eq("l1_drop", {31'd0, r1_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
